mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 37 +++
 rtl/mau_lane_align.sv | 71 +++++++
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared types and constants for the load/store memory access unit:
//   - access size encodings carried on req_size
//   - the access FSM state enumeration
//   - default data-memory capacity
//   - a helper that flags misaligned accesses
// -----------------------------------------------------------------------------
package mem_access_pkg;

    localparam int MEM_BYTES_DEFAULT = 1024;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    // True for an illegal size or an access not aligned to its natural size.
    function automatic logic bad_size_or_align(input size_e size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// -----------------------------------------------------------------------------
// mau_lane_align
// Purely combinational big-endian lane handling for mem_access_unit.
//   size       : access size (byte / halfword / word)
//   offset     : byte offset within the word (addr[1:0])
//   is_signed  : sign-extend byte/halfword loads when high
//   rdata      : word read from memory, used for load extraction
//   old_word   : word captured by the read phase of a read-modify-write
//   wdata      : right-justified store data
//   load_data  : extracted, right-justified and extended load result
//   merged     : old_word with only the addressed lane replaced by wdata
// Offset 0 is the most significant byte (bits 31:24).
// -----------------------------------------------------------------------------
module mau_lane_align
    import mem_access_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    input  logic [31:0] rdata,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case statements can infer a latch.
        lane_byte = 8'h00;
        case (offset)
            2'd0: lane_byte = rdata[31:24];
            2'd1: lane_byte = rdata[23:16];
            2'd2: lane_byte = rdata[15:8];
            2'd3: lane_byte = rdata[7:0];
            default: lane_byte = 8'h00;
        endcase
        lane_half = offset[1] ? rdata[15:0] : rdata[31:16];

        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = {{24{is_signed & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_data = {{16{is_signed & lane_half[15]}}, lane_half};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0: merged[31:24] = wdata[7:0];
                    2'd1: merged[23:16] = wdata[7:0];
                    2'd2: merged[15:8]  = wdata[7:0];
                    2'd3: merged[7:0]   = wdata[7:0];
                    default: merged = old_word;
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) merged[15:0]  = wdata[15:0];
                else           merged[31:16] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Processor-side load/store unit in front of a word-wide, big-endian data
// memory with combinational read data.  Byte and halfword stores are done as
// read-modify-write.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_we/size/signed  : store flag, access size, sign-extend loads
//   req_addr/req_wdata  : byte address, right-justified store data
//   resp_valid/ready    : response handshake
//   resp_rdata/resp_err : load result (0 for stores/errors), error flag
//   mem_addr/wdata/we   : word-aligned memory address, write word, strobe
//   mem_rdata           : memory read word at mem_addr
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_we
);

    state_e      state, state_nx;

    logic        we_q;
    size_e       size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] cap_q;     // word captured in RD (read-modify-write source)
    logic [31:0] rdata_q;   // registered load result

    logic        accept;
    logic        err_now;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign accept  = (state == IDLE) && req_valid;
    assign err_now = bad_size_or_align(size_e'(req_size), req_addr[1:0])
                     || (req_addr >= 32'(MEM_BYTES));

    mau_lane_align u_lane_align (
        .size      (size_q),
        .offset    (addr_q[1:0]),
        .is_signed (signed_q),
        .rdata     (mem_rdata),
        .old_word  (cap_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // State register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (err_now)                          state_nx = RESP;
                    else if (!req_we)                     state_nx = RD;
                    else if (size_e'(req_size) == SZ_WORD) state_nx = WR;
                    else                                  state_nx = RD;
                end
            end
            RD:      state_nx = we_q ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    state_nx = resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: memory port is idle (all zero) outside RD and WR.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && err_q;
        resp_rdata = rdata_q;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_we     = 1'b0;
        case (state)
            RD: mem_addr = {addr_q[31:2], 2'b00};
            WR: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = merged;
                mem_we    = 1'b1;
            end
            default: ;
        endcase
    end

    // Request capture and datapath registers; request fields are only
    // sampled on acceptance, so req_* activity while busy is ignored.
    // NOTE: all captured data is cleared by reset so an aborted access
    // leaves nothing stale visible on resp_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            cap_q    <= 32'h0;
            rdata_q  <= 32'h0;
        end else if (accept) begin
            we_q     <= req_we;
            size_q   <= size_e'(req_size);
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= err_now;
            cap_q    <= 32'h0;
            rdata_q  <= 32'h0;
        end else if (state == RD) begin
            cap_q <= mem_rdata;
            if (!we_q) rdata_q <= load_data;
        end
    end

endmodule
